// File: rtl/prt_dp_pkg.sv
// Shared DP TX types: one lane symbol, the K28.5 fill symbol and parameter helpers.
package prt_dp_pkg;

   typedef struct packed {
      logic       disp_ctl;
      logic       disp_val;
      logic       k;
      logic [7:0] dat;
   } prt_dp_sym_t;

   localparam prt_dp_sym_t PRT_DP_SYM_FILL = '{disp_ctl: 1'b0, disp_val: 1'b0, k: 1'b1,
                                               dat: 8'hBC};

   // Symbols-per-lane values the lane datapath is built for.
   function automatic bit prt_dp_spl_legal(input int unsigned spl);
      return (spl == 1) || (spl == 2) || (spl == 4);
   endfunction

   function automatic int unsigned prt_dp_ceil_div(input int unsigned num, input int unsigned den);
      return (num + den - 1) / den;
   endfunction

endpackage

// File: rtl/prt_dp_tx_phy_if.sv
// Lane-to-PHY symbol bus; lane [0] carries P_SPL symbols, index 0 earliest in time.
interface prt_dp_tx_phy_if #(
   parameter int unsigned P_LANES = 1,
   parameter int unsigned P_SPL   = 2
);
   logic [P_SPL-1:0]      disp_ctl [P_LANES];
   logic [P_SPL-1:0]      disp_val [P_LANES];
   logic [P_SPL-1:0]      k        [P_LANES];
   logic [P_SPL-1:0][7:0] dat      [P_LANES];

   modport src (output disp_ctl, disp_val, k, dat);
   modport snk (input  disp_ctl, disp_val, k, dat);
endinterface

// File: rtl/prt_dptx_sym_dly.sv
// Symbol-granular delay line: history of the last P_MAX_SKEW symbols plus a window mux
// selecting P_SPL consecutive symbols D positions back from the current input.
module prt_dptx_sym_dly
   import prt_dp_pkg::*;
#(
   parameter int unsigned P_SPL      = 2,
   parameter int unsigned P_MAX_SKEW = 6,
   parameter prt_dp_sym_t P_FILL     = PRT_DP_SYM_FILL,
   localparam int unsigned W         = $clog2(P_MAX_SKEW + 1)
) (
   input  logic        CLK_IN,
   input  logic        flush,
   input  logic [W-1:0] D,
   input  prt_dp_sym_t sym_in  [P_SPL],
   output prt_dp_sym_t sym_out [P_SPL]
);

   prt_dp_sym_t hist [P_MAX_SKEW];
   prt_dp_sym_t strm [P_MAX_SKEW + P_SPL];

   // Stream = history (oldest first) followed by the current word
   always_comb begin
      for (int i = 0; i < P_MAX_SKEW; i++) strm[i] = hist[i];
      for (int j = 0; j < P_SPL; j++) strm[P_MAX_SKEW + j] = sym_in[j];
   end

   // Keep the newest P_MAX_SKEW symbols; a flush discards everything in flight
   always_ff @(posedge CLK_IN) begin
      for (int i = 0; i < P_MAX_SKEW; i++) begin
         hist[i] <= flush ? P_FILL : strm[i + P_SPL];
      end
   end

   // Window mux; constant indices per candidate skew keep every select in range
   always_comb begin
      for (int j = 0; j < P_SPL; j++) begin
         sym_out[j] = P_FILL;
         for (int d = 0; d <= P_MAX_SKEW; d++) begin
            if (D == W'(d)) sym_out[j] = strm[P_MAX_SKEW + j - d];
         end
      end
   end

endmodule

// File: rtl/prt_dptx_skew_prog.sv
// Programmable inter-lane skew for one DP TX lane: clamps and registers the requested skew,
// flushes the delay line on reset/update and flags the refill window on STS_BUSY_OUT.
module prt_dptx_skew_prog
   import prt_dp_pkg::*;
#(
   parameter int unsigned P_LANE      = 0,
   parameter int unsigned P_SPL       = 2,
   parameter int unsigned P_SKEW_STEP = 2,
   parameter int unsigned P_MAX_SKEW  = 6,
   parameter logic [7:0]  P_FILL_DAT  = 8'hBC,
   localparam int unsigned W          = $clog2(P_MAX_SKEW + 1)
) (
   input  logic          CLK_IN,
   input  logic          RST_IN,
   input  logic [W-1:0]  CFG_SKEW_IN,
   input  logic          CFG_UPD_IN,
   output logic [W-1:0]  STS_SKEW_OUT,
   output logic          STS_BUSY_OUT,
   prt_dp_tx_phy_if.snk  LNK_SNK_IF,
   prt_dp_tx_phy_if.src  LNK_SRC_IF
);

   localparam int unsigned RST_SKEW = (P_LANE * P_SKEW_STEP < P_MAX_SKEW) ?
                                      P_LANE * P_SKEW_STEP : P_MAX_SKEW;
   localparam int unsigned RST_CNT  = prt_dp_ceil_div(RST_SKEW, P_SPL);
   localparam prt_dp_sym_t FILL     = '{disp_ctl: 1'b0, disp_val: 1'b0, k: 1'b1,
                                        dat: P_FILL_DAT};

   localparam logic [0:0] ST_RUN    = 1'b0;
   localparam logic [0:0] ST_REFILL = 1'b1;

   if (!prt_dp_spl_legal(P_SPL) || (P_MAX_SKEW < 1)) begin : g_param_err
      $error("prt_dptx_skew_prog: P_SPL must be 1, 2 or 4 and P_MAX_SKEW >= 1");
   end

   logic [W-1:0] skew_q, skew_d, skew_clamp;
   logic [W-1:0] cnt_q, cnt_d;
   logic [0:0]   st_q, st_d;
   logic         flush;
   prt_dp_sym_t  sym_in  [P_SPL];
   prt_dp_sym_t  sym_out [P_SPL];

   assign skew_clamp   = (CFG_SKEW_IN > W'(P_MAX_SKEW)) ? W'(P_MAX_SKEW) : CFG_SKEW_IN;
   assign flush        = RST_IN | CFG_UPD_IN;
   assign STS_SKEW_OUT = skew_q;
   assign STS_BUSY_OUT = (cnt_q != '0);

   // Next state: an update reloads skew and refill count, otherwise count the refill down
   always_comb begin
      skew_d = skew_q;
      cnt_d  = (cnt_q != '0) ? cnt_q - W'(1) : '0;
      st_d   = st_q;
      if (CFG_UPD_IN) begin
         skew_d = skew_clamp;
         cnt_d  = W'(prt_dp_ceil_div(32'(skew_clamp), P_SPL));
         st_d   = (skew_clamp != '0) ? ST_REFILL : ST_RUN;
      end else if ((st_q == ST_REFILL) && (cnt_q <= W'(1))) begin
         st_d = ST_RUN;
      end
   end

   // Control registers; reset takes priority over a coincident update
   always_ff @(posedge CLK_IN) begin
      if (RST_IN) begin
         skew_q <= W'(RST_SKEW);
         cnt_q  <= W'(RST_CNT);
         st_q   <= (RST_SKEW > 0) ? ST_REFILL : ST_RUN;
      end else begin
         skew_q <= skew_d;
         cnt_q  <= cnt_d;
         st_q   <= st_d;
      end
   end

   // Unpack lane 0 of the sink bus into symbols
   always_comb begin
      for (int j = 0; j < P_SPL; j++) begin
         sym_in[j].disp_ctl = LNK_SNK_IF.disp_ctl[0][j];
         sym_in[j].disp_val = LNK_SNK_IF.disp_val[0][j];
         sym_in[j].k        = LNK_SNK_IF.k[0][j];
         sym_in[j].dat      = LNK_SNK_IF.dat[0][j];
      end
   end

   prt_dptx_sym_dly #(
      .P_SPL      (P_SPL),
      .P_MAX_SKEW (P_MAX_SKEW),
      .P_FILL     (FILL)
   ) u_dly (
      .CLK_IN  (CLK_IN),
      .flush   (flush),
      .D       (skew_q),
      .sym_in  (sym_in),
      .sym_out (sym_out)
   );

   // Pack skewed symbols onto lane 0 of the source bus
   always_comb begin
      for (int j = 0; j < P_SPL; j++) begin
         LNK_SRC_IF.disp_ctl[0][j] = sym_out[j].disp_ctl;
         LNK_SRC_IF.disp_val[0][j] = sym_out[j].disp_val;
         LNK_SRC_IF.k[0][j]        = sym_out[j].k;
         LNK_SRC_IF.dat[0][j]      = sym_out[j].dat;
      end
   end

endmodule
